uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one uart_tx transmitter among N byte-stream requesters. It grants one requester at a time and issues a one-cycle tx_start with the granted byte. It waits for tx_done_tick before issuing the next byte. A grant is held for a multi-byte message until the requester marks the last byte or a burst cap is reached, so messages from different requesters never interleave.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N byte-stream requesters.
// A grant is held for a whole message, up to an optional burst cap.
module uart_tx_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned PTR_W     = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic [8*N-1:0]   req_data_i,
    input  logic [N-1:0]     req_last_i,
    output logic [N-1:0]     ack_o,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_id_o,
    output logic             busy_o,
    output logic             tx_start_o,
    output logic [7:0]       din_o,
    input  logic             tx_done_tick_i
);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    localparam logic [PTR_W:0]   NumReq  = (PTR_W + 1)'(N);
    localparam logic [PTR_W-1:0] LastIdx = PTR_W'(N - 1);
    localparam logic [7:0]       MaxB    = 8'(MAX_BURST);
    localparam bit               CapEn   = (MAX_BURST != 0);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  gid_q, gid_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [N-1:0]      ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        din_q, din_d;

    logic [PTR_W-1:0]  win;
    logic              found;
    logic [PTR_W:0]    sum;
    logic [PTR_W:0]    cand;
    logic              release_now;

    // Search req_i starting at ptr_q, wrapping modulo N.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum  = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            cand = (sum >= NumReq) ? (sum - NumReq) : sum;
            if (!found && req_i[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = cand[PTR_W-1:0];
            end
        end
    end

    assign release_now = last_q || (CapEn && (cnt_q == MaxB)) || !req_i[gid_q];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        grant_d    = grant_q;
        ack_d      = '0;
        busy_d     = busy_q;
        tx_start_d = 1'b0;
        din_d      = din_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gid_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    ack_d[win]   = 1'b1;
                    din_d        = req_data_i[{win, 3'b000} +: 8];
                    last_d       = req_last_i[win];
                    cnt_d        = 8'd1;
                    busy_d       = 1'b1;
                    tx_start_d   = 1'b1;
                    state_d      = StSend;
                end
            end
            StSend: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done_tick_i) begin
                    if (release_now) begin
                        state_d = StIdle;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        ptr_d   = (gid_q == LastIdx) ? '0 : gid_q + 1'b1;
                    end else begin
                        din_d        = req_data_i[{gid_q, 3'b000} +: 8];
                        last_d       = req_last_i[gid_q];
                        cnt_d        = cnt_q + 8'd1;
                        ack_d[gid_q] = 1'b1;
                        tx_start_d   = 1'b1;
                        state_d      = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            gid_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            din_q      <= din_d;
        end
    end

    assign ack_o      = ack_q;
    assign grant_o    = grant_q;
    assign grant_id_o = gid_q;
    assign busy_o     = busy_q;
    assign tx_start_o = tx_start_q;
    assign din_o      = din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a fixed-latency
// uart_tx stand-in, and a log of every tx_start compared to hand-made tables.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic        use_cap = 1'b0;

    logic [3:0] ack_a, grant_a, ack_b, grant_b;
    logic [1:0] gid_a, gid_b;
    logic       busy_a, busy_b, txs_a, txs_b, done_a, done_b;
    logic [7:0] din_a, din_b;
    logic [2:0] cnt_a, cnt_b;

    logic [3:0] ack, grant;
    logic [1:0] gid;
    logic       busy, tx_start, done;
    logic [7:0] din;

    int cyc = 0;
    int last_done = 0;
    int n_chk = 0;
    int n_err = 0;
    int t_req = 0;
    logic [3:0] pend = '0;
    logic [8:0] q [4][$];

    typedef struct {
        logic [7:0] din;
        logic [3:0] ack;
        logic [3:0] grant;
        int         cyc;
        int         gap;
    } ent_t;
    ent_t log_q[$];

    always #5 clk = ~clk;

    // Instance a: default cap of 16; instance b: cap of 2.
    uart_tx_arbiter #(.N(4), .MAX_BURST(16), .PTR_W(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(use_cap ? 4'b0 : req), .req_data_i(req_data), .req_last_i(req_last),
        .ack_o(ack_a), .grant_o(grant_a), .grant_id_o(gid_a), .busy_o(busy_a),
        .tx_start_o(txs_a), .din_o(din_a), .tx_done_tick_i(done_a)
    );

    uart_tx_arbiter #(.N(4), .MAX_BURST(2), .PTR_W(2)) dut_cap (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(use_cap ? req : 4'b0), .req_data_i(req_data), .req_last_i(req_last),
        .ack_o(ack_b), .grant_o(grant_b), .grant_id_o(gid_b), .busy_o(busy_b),
        .tx_start_o(txs_b), .din_o(din_b), .tx_done_tick_i(done_b)
    );

    assign ack      = use_cap ? ack_b   : ack_a;
    assign grant    = use_cap ? grant_b : grant_a;
    assign gid      = use_cap ? gid_b   : gid_a;
    assign busy     = use_cap ? busy_b  : busy_a;
    assign tx_start = use_cap ? txs_b   : txs_a;
    assign din      = use_cap ? din_b   : din_a;
    assign done     = use_cap ? done_b  : done_a;

    // uart_tx stand-in: done tick five cycles after tx_start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0; done_a <= 1'b0; cnt_b <= '0; done_b <= 1'b0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            if (txs_a) cnt_a <= 3'd4;
            else if (cnt_a != 0) begin cnt_a <= cnt_a - 1; if (cnt_a == 1) done_a <= 1'b1; end
            if (txs_b) cnt_b <= 3'd4;
            else if (cnt_b != 0) begin cnt_b <= cnt_b - 1; if (cnt_b == 1) done_b <= 1'b1; end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) log_q.push_back('{din, ack, grant, cyc, cyc - last_done});
        if (done) last_done = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() != 0) begin
                e = q[i][0];
                req[i] = 1'b1;
                req_data[i*8 +: 8] = e[7:0];
                req_last[i] = e[8];
            end else begin
                req[i] = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i] = 1'b0;
            end
        end
    endtask

    // Pop a byte the cycle after its ack, then present the next one.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (pend[i] && q[i].size() != 0) void'(q[i].pop_front());
        pend = ack;
        drive();
    endtask

    task automatic start();
        log_q.delete();
        drive();
        t_req = cyc;
    endtask

    task automatic wait_idle(input string tag, input int n_exp);
        int n = 0;
        while (n < 400) begin
            step();
            n++;
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 &&
                q[3].size() == 0 && pend == 0 && !busy && !tx_start) break;
        end
        chk({tag, "_timeout"}, 32'(n < 400), 1);
        repeat (3) step();
        chk({tag, "_grant_idle"}, 32'(grant), 0);
        chk({tag, "_busy_idle"}, 32'(busy), 0);
        chk({tag, "_count"}, log_q.size(), n_exp);
    endtask

    task automatic check_ent(input string tag, input int k, input logic [7:0] d,
                             input int id, input int gap);
        if (k >= log_q.size()) begin
            chk($sformatf("%s_%0d_present", tag, k), log_q.size(), k + 1);
        end else begin
            chk($sformatf("%s_%0d_din", tag, k), 32'(log_q[k].din), 32'(d));
            chk($sformatf("%s_%0d_ack", tag, k), 32'(log_q[k].ack), 32'd1 << id);
            chk($sformatf("%s_%0d_grant", tag, k), 32'(log_q[k].grant), 32'd1 << id);
            if (gap >= 0) chk($sformatf("%s_%0d_gap", tag, k), log_q[k].gap, gap);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ack"}, 32'(ack_a), 0);
        chk({tag, "_grant"}, 32'(grant_a), 0);
        chk({tag, "_gid"}, 32'(gid_a), 0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_txs"}, 32'(txs_a), 0);
        chk({tag, "_din"}, 32'(din_a), 0);
    endtask

    initial begin
        int n;
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single byte: tx_start one cycle after req, then release.
        q[0].push_back({1'b1, 8'hA5});
        start();
        wait_idle("t1", 1);
        check_ent("t1", 0, 8'hA5, 0, -1);
        if (log_q.size() != 0) chk("t1_latency", log_q[0].cyc - t_req, 1);

        // ptr is now 1, so req1 beats req0.
        q[0].push_back({1'b1, 8'hB0});
        q[1].push_back({1'b1, 8'hB1});
        start();
        wait_idle("t1b", 2);
        check_ent("t1b", 0, 8'hB1, 1, -1);
        check_ent("t1b", 1, 8'hB0, 0, 2);

        // Round robin between req1 and req3, twice.
        for (int r = 0; r < 2; r++) begin
            q[1].push_back({1'b1, 8'h11});
            q[3].push_back({1'b1, 8'h33});
            start();
            wait_idle($sformatf("t2r%0d", r), 2);
            check_ent($sformatf("t2r%0d", r), 0, 8'h11, 1, -1);
            check_ent($sformatf("t2r%0d", r), 1, 8'h33, 3, 2);
        end

        // Message lock: req0 three bytes while req2 waits.
        q[0].push_back({1'b0, 8'h01});
        q[0].push_back({1'b0, 8'h02});
        q[0].push_back({1'b1, 8'h03});
        q[2].push_back({1'b1, 8'h22});
        start();
        wait_idle("t3", 4);
        check_ent("t3", 0, 8'h01, 0, -1);
        check_ent("t3", 1, 8'h02, 0, 1);
        check_ent("t3", 2, 8'h03, 0, 1);
        check_ent("t3", 3, 8'h22, 2, 2);

        // Requester drop after first ack.
        q[3].push_back({1'b0, 8'h77});
        start();
        wait_idle("t5", 1);
        check_ent("t5", 0, 8'h77, 3, -1);

        // Burst cap of 2 on the second instance.
        use_cap = 1'b1;
        for (int i = 0; i < 4; i++) q[1].push_back({1'b0, 8'(8'h40 + i)});
        q[2].push_back({1'b1, 8'h50});
        start();
        wait_idle("t4", 5);
        check_ent("t4", 0, 8'h40, 1, -1);
        check_ent("t4", 1, 8'h41, 1, 1);
        check_ent("t4", 2, 8'h50, 2, 2);
        check_ent("t4", 3, 8'h42, 1, 2);
        check_ent("t4", 4, 8'h43, 1, 1);
        use_cap = 1'b0;
        step();

        // Move ptr to 1, then reset while req2 is mid-message.
        q[0].push_back({1'b1, 8'h60});
        start();
        wait_idle("t6pre", 1);
        check_ent("t6pre", 0, 8'h60, 0, -1);
        q[2].push_back({1'b0, 8'h80});
        q[2].push_back({1'b0, 8'h81});
        q[2].push_back({1'b1, 8'h82});
        start();
        n = 0;
        while (n < 100 && !(busy && !tx_start && log_q.size() != 0)) begin
            step();
            n++;
        end
        chk("t6_wait_busy", 32'(busy), 1);
        chk("t6_wait_grant", 32'(grant), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("t6_reset");
        for (int i = 0; i < 4; i++) q[i].delete();
        pend = '0;
        q[0].push_back({1'b1, 8'h90});
        q[1].push_back({1'b1, 8'h91});
        drive();
        log_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("t6", 2);
        check_ent("t6", 0, 8'h90, 0, -1);
        check_ent("t6", 1, 8'h91, 1, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
